// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, opcodes and bus layouts for the execute stage.
package ex_stage_pkg;

    localparam int unsigned DW           = 32;
    localparam int unsigned ID_TO_EX_WD  = 146;
    localparam int unsigned EX_TO_MEM_WD = 76;
    localparam int unsigned EX_TO_ID_WD  = 39;
    localparam int unsigned STALL_BUS    = 6;
    localparam int unsigned STALL_EX     = 2;
    localparam int unsigned STALL_MEM    = 3;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,  ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,  ALU_SLT  = 4'd6,  ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,  ALU_SRL  = 4'd9,  ALU_SRA  = 4'd10, ALU_LUI  = 4'd11,
        ALU_MFHI = 4'd12, ALU_MFLO = 4'd13, ALU_MTHI = 4'd14, ALU_MTLO = 4'd15
    } alu_op_e;

    localparam logic [1:0] DIV_NONE = 2'b00;
    localparam logic [1:0] DIV_S    = 2'b10;
    localparam logic [1:0] DIV_U    = 2'b11;

    typedef struct packed {
        logic [DW-1:0] pc;
        alu_op_e       alu_op;
        logic [1:0]    div_op;
        logic          data_ram_en;
        logic [3:0]    data_ram_wen;
        logic          sel_rf_res;
        logic          rf_we;
        logic [4:0]    rf_waddr;
        logic [DW-1:0] src1;
        logic [DW-1:0] src2;
        logic [DW-1:0] store_data;
    } id_to_ex_t;

    typedef struct packed {
        logic [DW-1:0] pc;
        logic          data_ram_en;
        logic [3:0]    data_ram_wen;
        logic          sel_rf_res;
        logic          rf_we;
        logic [4:0]    rf_waddr;
        logic [DW-1:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic          sel_rf_res;
        logic          rf_we;
        logic [4:0]    rf_waddr;
        logic [DW-1:0] ex_result;
    } ex_to_id_t;

    // Magnitude of a possibly-signed operand.
    function automatic logic [DW-1:0] mag(input logic [DW-1:0] v, input logic is_signed);
        return (is_signed && v[DW-1]) ? DW'(-v) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// Pipeline-side signal bundle of the execute stage: ID input, MEM/ID outputs, SRAM request.
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic [STALL_BUS-1:0]    stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [DW-1:0]           data_sram_addr;
    logic [DW-1:0]           data_sram_wdata;
    logic                    stallreq_for_ex;

    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage_div.sv
// ex_div: 32-cycle restoring divider with sign fix-up; holds DONE until the instruction leaves EX.
module ex_div
    import ex_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic          release_i,
    input  logic [DW-1:0] src1_i,
    input  logic [DW-1:0] src2_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          wr_c,
    output logic [DW-1:0] quo_c,
    output logic [DW-1:0] rem_c
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e        state_q;
    logic [4:0]    cnt_q;
    logic [DW-1:0] q_q, r_q, d_q, a_raw_q;
    logic          qneg_q, rneg_q, dz_q;

    logic [DW:0]   r_sh, diff;
    logic [DW-1:0] q_nx, r_nx;

    // One restoring step; on the last step the fixed-up result goes straight to HI/LO.
    always_comb begin
        r_sh = {r_q, q_q[DW-1]};
        diff = r_sh - {1'b0, d_q};
        q_nx = {q_q[DW-2:0], 1'b0};
        r_nx = r_sh[DW-1:0];
        if (!diff[DW]) begin
            q_nx = {q_q[DW-2:0], 1'b1};
            r_nx = diff[DW-1:0];
        end
        quo_c  = dz_q ? '1      : (qneg_q ? DW'(-q_nx) : q_nx);
        rem_c  = dz_q ? a_raw_q : (rneg_q ? DW'(-r_nx) : r_nx);
        wr_c   = (state_q == S_BUSY) && (cnt_q == 5'd31);
        busy_o = (state_q == S_BUSY);
        done_o = (state_q == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            d_q     <= '0;
            a_raw_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q <= S_BUSY;
                    cnt_q   <= '0;
                    q_q     <= mag(src1_i, signed_i);
                    d_q     <= mag(src2_i, signed_i);
                    r_q     <= '0;
                    a_raw_q <= src1_i;
                    qneg_q  <= signed_i && (src1_i[DW-1] ^ src2_i[DW-1]);
                    rneg_q  <= signed_i && src1_i[DW-1];
                    dz_q    <= (src2_i == '0);
                end
                S_BUSY: begin
                    q_q   <= q_nx;
                    r_q   <= r_nx;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= S_DONE;
                end
                S_DONE: if (release_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, ALU, data SRAM request, HI/LO.
// Define EX_DIV_EN to include the multi-cycle divider; otherwise div_op is ignored.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  ex_if
);
    id_to_ex_t     bus_q;
    logic [DW-1:0] hi_q, lo_q;
    logic [DW-1:0] alu_res, ex_result, sram_addr;
    logic          div_wr;
    logic [DW-1:0] div_quo, div_rem;
    ex_to_mem_t    mem_c;
    ex_to_id_t     fwd_c;
    logic          unused_stall;

    assign unused_stall = ^{ex_if.stall[5:4], ex_if.stall[1:0]};

    // A stopped EX with a running MEM inserts a bubble.
    always_ff @(posedge clk) begin
        if (rst)
            bus_q <= '0;
        else if (ex_if.stall[STALL_EX] == STOP && ex_if.stall[STALL_MEM] == NO_STOP)
            bus_q <= '0;
        else if (ex_if.stall[STALL_EX] == NO_STOP)
            bus_q <= id_to_ex_t'(ex_if.id_to_ex_bus);
    end

`ifdef EX_DIV_EN
    logic div_busy, div_done;

    ex_div u_div (
        .clk       (clk),
        .rst       (rst),
        .start_i   (bus_q.div_op[1]),
        .signed_i  (~bus_q.div_op[0]),
        .release_i (ex_if.stall[STALL_EX] == NO_STOP),
        .src1_i    (bus_q.src1),
        .src2_i    (bus_q.src2),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .wr_c      (div_wr),
        .quo_c     (div_quo),
        .rem_c     (div_rem)
    );

    assign ex_if.stallreq_for_ex = (!div_busy && !div_done && bus_q.div_op[1]) || div_busy;
`else
    logic unused_div;

    assign unused_div            = ^bus_q.div_op;
    assign div_wr                = 1'b0;
    assign div_quo               = '0;
    assign div_rem               = '0;
    assign ex_if.stallreq_for_ex = 1'b0;
`endif

    always_comb begin
        sram_addr = bus_q.src1 + bus_q.src2;
        alu_res   = '0;
        case (bus_q.alu_op)
            ALU_ADD:  alu_res = bus_q.src1 + bus_q.src2;
            ALU_SUB:  alu_res = bus_q.src1 - bus_q.src2;
            ALU_AND:  alu_res = bus_q.src1 & bus_q.src2;
            ALU_OR:   alu_res = bus_q.src1 | bus_q.src2;
            ALU_XOR:  alu_res = bus_q.src1 ^ bus_q.src2;
            ALU_NOR:  alu_res = ~(bus_q.src1 | bus_q.src2);
            ALU_SLT:  alu_res = DW'($signed(bus_q.src1) < $signed(bus_q.src2));
            ALU_SLTU: alu_res = DW'(bus_q.src1 < bus_q.src2);
            ALU_SLL:  alu_res = bus_q.src2 << bus_q.src1[4:0];
            ALU_SRL:  alu_res = bus_q.src2 >> bus_q.src1[4:0];
            ALU_SRA:  alu_res = DW'($signed(bus_q.src2) >>> bus_q.src1[4:0]);
            ALU_LUI:  alu_res = {bus_q.src2[15:0], 16'h0000};
            ALU_MFHI: alu_res = hi_q;
            ALU_MFLO: alu_res = lo_q;
            ALU_MTHI: alu_res = bus_q.src1;
            ALU_MTLO: alu_res = bus_q.src1;
            default:  alu_res = '0;
        endcase
        ex_result = bus_q.data_ram_en ? sram_addr : alu_res;
    end

    // HI/LO: divide completion, then MTHI/MTLO.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (div_wr) begin
                hi_q <= div_rem;
                lo_q <= div_quo;
            end
            if (bus_q.alu_op == ALU_MTHI) hi_q <= bus_q.src1;
            if (bus_q.alu_op == ALU_MTLO) lo_q <= bus_q.src1;
        end
    end

    always_comb begin
        mem_c.pc           = bus_q.pc;
        mem_c.data_ram_en  = bus_q.data_ram_en;
        mem_c.data_ram_wen = bus_q.data_ram_wen;
        mem_c.sel_rf_res   = bus_q.sel_rf_res;
        mem_c.rf_we        = bus_q.rf_we;
        mem_c.rf_waddr     = bus_q.rf_waddr;
        mem_c.ex_result    = ex_result;
        fwd_c.sel_rf_res   = bus_q.sel_rf_res;
        fwd_c.rf_we        = bus_q.rf_we;
        fwd_c.rf_waddr     = bus_q.rf_waddr;
        fwd_c.ex_result    = ex_result;
    end

    assign ex_if.ex_to_mem_bus   = mem_c;
    assign ex_if.ex_to_id_bus    = fwd_c;
    assign ex_if.data_sram_en    = bus_q.data_ram_en;
    assign ex_if.data_sram_wen   = bus_q.data_ram_wen;
    assign ex_if.data_sram_addr  = sram_addr;
    assign ex_if.data_sram_wdata = bus_q.store_data;
endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed instructions, expected EX->MEM view checked as it leaves EX.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct packed {
        logic [75:0] mem;
        logic [38:0] idb;
        logic        sen;
        logic [3:0]  swen;
        logic [31:0] saddr;
        logic [31:0] swdata;
        logic        chk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] extra_stall;
    int         errors = 0;
    int         checks = 0;
    exp_t       sb[$];

    ex_stage_if bus_if();

    ex_stage u_dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (bus_if)
    );

    always #5 clk = ~clk;

    // Stand-in for the stall controller: an EX request freezes everything up to and including EX->MEM.
    always_comb bus_if.stall = bus_if.stallreq_for_ex ? 6'b001111 : extra_stall;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Pops one expectation each time a real instruction advances from EX into MEM.
    always @(negedge clk) begin
        if (!rst && bus_if.ex_to_mem_bus[75:44] != 32'h0 && bus_if.stall[3] == 1'b0) begin
            logic [183:0] got, exp;
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out pc=%h got=present exp=none", bus_if.ex_to_mem_bus[75:44]);
            end else begin
                e   = sb.pop_front();
                got = {bus_if.ex_to_mem_bus, bus_if.ex_to_id_bus, bus_if.data_sram_en,
                       bus_if.data_sram_wen, bus_if.data_sram_addr, bus_if.data_sram_wdata};
                exp = {e.mem, e.idb, e.sen, e.swen, e.saddr, e.swdata};
                if (!e.chk) begin
                    got[139:108] = '0; exp[139:108] = '0;
                    got[100:69]  = '0; exp[100:69]  = '0;
                end
                if (got !== exp) begin
                    errors++;
                    $display("FAIL out_pc_%h got=%h exp=%h", e.mem[75:44], got, exp);
                end
            end
        end
    end

    // Issue one instruction into EX once EX accepts, optionally pushing its expected output.
    task automatic op(input logic [31:0] pc, input logic [3:0] alu, input logic [1:0] dv,
                      input logic en, input logic [3:0] wen, input logic sel, input logic we,
                      input logic [4:0] wa, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [31:0] sd, input logic [31:0] res, input logic [31:0] addr,
                      input logic chk, input logic push);
        id_to_ex_t b;
        exp_t      e;
        int        n;
        b.pc = pc; b.alu_op = alu_op_e'(alu); b.div_op = dv; b.data_ram_en = en;
        b.data_ram_wen = wen; b.sel_rf_res = sel; b.rf_we = we; b.rf_waddr = wa;
        b.src1 = s1; b.src2 = s2; b.store_data = sd;
        e.mem = {pc, en, wen, sel, we, wa, res};
        e.idb = {sel, we, wa, res};
        e.sen = en; e.swen = wen; e.saddr = addr; e.swdata = sd; e.chk = chk;
        n = 0;
        @(negedge clk);
        while (bus_if.stall[2] && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("issue_wait", 128'(n), 128'(0));
        bus_if.id_to_ex_bus = b;
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        bus_if.id_to_ex_bus = '0;
    endtask

    task automatic count_stallreq(input string name, input int exp_n);
        int n;
        n = 0;
        while (bus_if.stallreq_for_ex && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        check(name, 128'(n), 128'(exp_n));
    endtask

    initial begin
        rst = 1'b1;
        extra_stall = 6'b0;
        bus_if.id_to_ex_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem",   128'(bus_if.ex_to_mem_bus), 128'(0));
        check("rst_id",    128'(bus_if.ex_to_id_bus), 128'(0));
        check("rst_sram",  128'({bus_if.data_sram_en, bus_if.data_sram_wen,
                                 bus_if.data_sram_addr, bus_if.data_sram_wdata}), 128'(0));
        check("rst_stall", 128'(bus_if.stallreq_for_ex), 128'(0));
        rst = 1'b0;

        //  pc        alu    div   en   wen    sel   we    wa     src1          src2          sd            result        addr
        op(32'h100, 4'd0,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h7FFFFFFF, 32'h00000001, 32'h0,        32'h80000000, 32'h80000000, 1'b1, 1'b1);
        op(32'h104, 4'd6,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd4, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000001, 32'h00000000, 1'b1, 1'b1);
        op(32'h108, 4'd7,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd5, 32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1);
        op(32'h10C, 4'd1,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd6, 32'h00000005, 32'h00000007, 32'h0,        32'hFFFFFFFE, 32'h0000000C, 1'b1, 1'b1);
        op(32'h110, 4'd10, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd7, 32'h00000004, 32'h80000000, 32'h0,        32'hF8000000, 32'h80000004, 1'b1, 1'b1);
        op(32'h114, 4'd11, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'h00000000, 32'h00001234, 32'h0,        32'h12340000, 32'h00001234, 1'b1, 1'b1);
        op(32'h118, 4'd5,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd9, 32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        32'h00000F0F, 32'hFFFFF0F0, 1'b1, 1'b1);
        // store word, then load
        op(32'h11C, 4'd0,  2'b00, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0, 32'h00001000, 32'h00000008, 32'hDEADBEEF, 32'h00001008, 32'h00001008, 1'b1, 1'b1);
        op(32'h120, 4'd0,  2'b00, 1'b1, 4'h0, 1'b1, 1'b1, 5'd9, 32'h00002000, 32'h00000004, 32'h0,        32'h00002004, 32'h00002004, 1'b1, 1'b1);
        // MTHI/MFHI, MTLO/MFLO back to back
        op(32'h124, 4'd14, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'hCAFEF00D, 32'h00000000, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1);
        op(32'h128, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'hCAFEF00D, 32'h00000000, 1'b1, 1'b1);
        op(32'h12C, 4'd15, 2'b00, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h12345678, 32'h00000000, 32'h0,        32'h12345678, 32'h12345678, 1'b1, 1'b1);
        op(32'h130, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'h12345678, 32'h00000000, 1'b1, 1'b1);

        // bubble: EX stopped while MEM runs
        op(32'h134, 4'd0,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h00000001, 32'h00000002, 32'h0,        32'h00000003, 32'h00000003, 1'b1, 1'b1);
        extra_stall = 6'b000111;
        @(posedge clk); #1;
        check("bubble_mem", 128'(bus_if.ex_to_mem_bus), 128'(0));
        extra_stall = 6'b0;

`ifdef EX_DIV_EN
        // DIV -7/2
        op(32'h200, 4'd0,  2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFB, 1'b0, 1'b1);
        count_stallreq("div_stall_len", 33);
        op(32'h204, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b1);
        op(32'h208, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        // DIVU 7/0 with MEM held 5 cycles in DONE
        op(32'h20C, 4'd0,  2'b11, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h00000007, 32'h00000000, 32'h0,        32'h0,        32'h00000007, 1'b0, 1'b1);
        count_stallreq("divu_stall_len", 33);
        extra_stall = 6'b001111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("done_hold_stallreq", 128'(bus_if.stallreq_for_ex), 128'(0));
            @(posedge clk); #1;
        end
        extra_stall = 6'b0;
        op(32'h210, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        op(32'h214, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'h00000007, 32'h00000000, 1'b1, 1'b1);
        // DIV 7/-2: remainder keeps the dividend's sign
        op(32'h218, 4'd0,  2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h00000007, 32'hFFFFFFFE, 32'h0,        32'h0,        32'h00000005, 1'b0, 1'b1);
        count_stallreq("div2_stall_len", 33);
        op(32'h21C, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b1);
        op(32'h220, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'h00000001, 32'h00000000, 1'b1, 1'b1);
        // reset in the middle of a divide
        op(32'h300, 4'd0,  2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'h00000064, 32'h00000007, 32'h0,        32'h0,        32'h0000006B, 1'b0, 1'b0);
        repeat (11) @(posedge clk);
        #1;
        check("busy_before_rst", 128'(bus_if.stallreq_for_ex), 128'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_stall", 128'(bus_if.stallreq_for_ex), 128'(0));
        check("rst_mid_mem",   128'(bus_if.ex_to_mem_bus), 128'(0));
        rst = 1'b0;
        op(32'h304, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1);
        op(32'h308, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1);
`else
        // divider absent: div_op is a no-op and HI/LO are untouched
        op(32'h200, 4'd0,  2'b10, 1'b0, 4'h0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFF9, 32'h00000002, 32'h0,        32'h0,        32'hFFFFFFFB, 1'b0, 1'b1);
        check("nodiv_stallreq", 128'(bus_if.stallreq_for_ex), 128'(0));
        op(32'h204, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'hCAFEF00D, 32'h00000000, 1'b1, 1'b1);
        op(32'h208, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'h12345678, 32'h00000000, 1'b1, 1'b1);
        op(32'h300, 4'd0,  2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd1, 32'h00000001, 32'h00000001, 32'h0,        32'h0,        32'h0,        1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_stall", 128'(bus_if.stallreq_for_ex), 128'(0));
        check("rst_mid_mem",   128'(bus_if.ex_to_mem_bus), 128'(0));
        rst = 1'b0;
        op(32'h304, 4'd12, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h00000000, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1);
        op(32'h308, 4'd13, 2'b00, 1'b0, 4'h0, 1'b0, 1'b1, 5'd3, 32'h00000000, 32'h00000000, 32'h0,        32'h00000000, 32'h00000000, 1'b1, 1'b1);
`endif

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
